// File: rtl/compare_alarm_monitor.sv
// Hysteresis alarm driven by a magnitude comparator's less/equal/greater flags.
// The alarm raises after SET_COUNT consecutive "greater" samples and drops after
// CLR_COUNT consecutive "less or equal" samples. Non-one-hot flag sets are
// reported and ignored. Alarm rises are counted in a saturating event counter.
module compare_alarm_monitor #(
  parameter int SET_COUNT = 3,
  parameter int CLR_COUNT = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic             flag_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] event_cnt
);

  // Bit 1 of the encoding is the alarm level, so alarm comes straight off a flop.
  typedef enum logic [1:0] {
    CLEAR     = 2'b00,
    ARMING    = 2'b01,
    ALARM     = 2'b10,
    DISARMING = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] SET_C = CNT_W'(SET_COUNT);
  localparam logic [CNT_W-1:0] CLR_C = CNT_W'(CLR_COUNT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ferr_q, ferr_d;
  logic             sticky_q, sticky_d;

  logic             onehot;
  logic             smp_hi;
  logic             smp_lo;
  logic             smp_bad;
  logic [CNT_W-1:0] run_inc;

  assign onehot  = (({less, equal, greater} == 3'b001) ||
                    ({less, equal, greater} == 3'b010) ||
                    ({less, equal, greater} == 3'b100));
  assign smp_hi  = in_valid && onehot && greater;
  assign smp_lo  = in_valid && onehot && !greater;
  assign smp_bad = in_valid && !onehot;
  assign run_inc = run_q + CNT_W'(1);

  // Next-state, run counter, pulse and event-counter logic.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    evt_d    = evt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    ferr_d   = 1'b0;
    sticky_d = sticky_q;

    if (smp_bad) begin
      // Bad flags are reported but leave the run untouched.
      ferr_d   = 1'b1;
      sticky_d = 1'b1;
    end else if (smp_hi) begin
      unique case (state_q)
        CLEAR: begin
          run_d   = CNT_W'(1);
          state_d = (SET_COUNT == 1) ? ALARM : ARMING;
        end
        ARMING: begin
          run_d = run_inc;
          if (run_inc == SET_C) state_d = ALARM;
        end
        ALARM: begin
          run_d = '0;
        end
        DISARMING: begin
          run_d   = '0;
          state_d = ALARM;
        end
        default: state_d = CLEAR;
      endcase
    end else if (smp_lo) begin
      unique case (state_q)
        CLEAR: begin
          run_d = '0;
        end
        ARMING: begin
          run_d   = '0;
          state_d = CLEAR;
        end
        ALARM: begin
          run_d   = CNT_W'(1);
          state_d = (CLR_COUNT == 1) ? CLEAR : DISARMING;
        end
        DISARMING: begin
          run_d = run_inc;
          if (run_inc == CLR_C) state_d = CLEAR;
        end
        default: state_d = CLEAR;
      endcase
    end

    // Edges are taken on the alarm level, so DISARMING->ALARM is not a rise.
    rise_d = !state_q[1] && state_d[1];
    fall_d = state_q[1] && !state_d[1];

    if (rise_d && (evt_q != {CNT_W{1'b1}})) evt_d = evt_q + CNT_W'(1);
  end

  // State, counters and output pulses; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      run_q    <= '0;
      evt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      ferr_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      evt_q    <= evt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      ferr_q   <= ferr_d;
      sticky_q <= sticky_d;
    end
  end

  assign alarm      = state_q[1];
  assign alarm_rise = rise_q;
  assign alarm_fall = fall_q;
  assign flag_err   = ferr_q;
  assign err_sticky = sticky_q;
  assign event_cnt  = evt_q;

endmodule

// File: tb/tb_compare_alarm_monitor.sv
// Bench for compare_alarm_monitor: directed scenarios plus randomized traffic,
// each checked against a level-and-run-length model of the hysteresis alarm.
module tb_compare_alarm_monitor;

  localparam int SET_COUNT = 3;
  localparam int CLR_COUNT = 2;
  localparam int CNT_W     = 4;
  localparam int EVT_MAX   = (1 << CNT_W) - 1;

  localparam logic [2:0] F_LT = 3'b100;  // {less, equal, greater}
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             less, equal, greater;
  logic             alarm, alarm_rise, alarm_fall, flag_err, err_sticky;
  logic [CNT_W-1:0] event_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: alarm level plus length of the current qualifying run.
  logic m_alarm, m_rise, m_fall, m_ferr, m_sticky;
  int   m_run;
  int   m_evt;

  compare_alarm_monitor #(
    .SET_COUNT(SET_COUNT),
    .CLR_COUNT(CLR_COUNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .alarm     (alarm),
    .alarm_rise(alarm_rise),
    .alarm_fall(alarm_fall),
    .flag_err  (flag_err),
    .err_sticky(err_sticky),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W+4:0] obs_vec();
    return {alarm, alarm_rise, alarm_fall, flag_err, err_sticky, event_cnt};
  endfunction

  function automatic logic [CNT_W+4:0] exp_vec();
    return {m_alarm, m_rise, m_fall, m_ferr, m_sticky, CNT_W'(m_evt)};
  endfunction

  task automatic model_reset();
    m_alarm = 0; m_rise = 0; m_fall = 0; m_ferr = 0; m_sticky = 0;
    m_run = 0; m_evt = 0;
  endtask

  // Hysteresis rule: count consecutive samples that argue against the current level.
  task automatic model_step(input logic v, input logic [2:0] f);
    m_rise = 0; m_fall = 0; m_ferr = 0;
    if (!v) return;
    if ($countones(f) != 1) begin
      m_ferr = 1; m_sticky = 1;
      return;
    end
    if (!m_alarm) begin
      if (f == F_GT) begin
        m_run++;
        if (m_run >= SET_COUNT) begin
          m_alarm = 1; m_rise = 1; m_run = 0;
          if (m_evt < EVT_MAX) m_evt++;
        end
      end else m_run = 0;
    end else begin
      if (f != F_GT) begin
        m_run++;
        if (m_run >= CLR_COUNT) begin
          m_alarm = 0; m_fall = 1; m_run = 0;
        end
      end else m_run = 0;
    end
  endtask

  // Apply one cycle of input, advance the model at the edge, return 1ns later.
  task automatic drive(input logic v, input logic [2:0] f);
    in_valid = v;
    {less, equal, greater} = f;
    @(posedge clk);
    model_step(v, f);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 0; {less, equal, greater} = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 0; {less, equal, greater} = 3'b000;
    #2;
    do_reset();
    #1;
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset: got %b expected %b", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, F_GT);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_set();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, F_GT);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL set[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({alarm, alarm_rise, event_cnt} !== {2'b11, CNT_W'(1)}) begin
      n_err++; $display("FAIL set_final: got %b expected %b", {alarm, alarm_rise, event_cnt}, {2'b11, CNT_W'(1)});
    end
    drive(1'b1, F_GT);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL set_hold: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_hysteresis();
    logic [2:0] seq [6] = '{F_GT, F_GT, F_EQ, F_GT, F_GT, F_GT};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, seq[i]);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL hyst[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      if (i < 5) begin
        n_vec++;
        if (alarm !== 1'b0) begin
          n_err++; $display("FAIL hyst_low[%0d]: got alarm=%b expected 0", i, alarm);
        end
      end
    end
  endtask

  task automatic test_clear();
    logic [2:0] seq [4] = '{F_LT, F_GT, F_EQ, F_LT};
    logic       exp_al [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    // Enters with alarm=1 and event_cnt=1 from test_hysteresis.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL clear[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if ({alarm, alarm_fall} !== {exp_al[i], (i == 3) ? 1'b1 : 1'b0}) begin
        n_err++; $display("FAIL clear_lvl[%0d]: got %b expected %b", i, {alarm, alarm_fall}, {exp_al[i], i == 3});
      end
    end
    drive(1'b0, F_LT);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL clear_pulse_end: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flag_err();
    logic [2:0] seq [7] = '{F_GT, 3'b011, 3'b000, 3'b111, F_GT, 3'b110, F_GT};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[i]);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL flagerr[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({alarm, alarm_rise, err_sticky} !== 3'b111) begin
      n_err++; $display("FAIL flagerr_sched: got %b expected 111", {alarm, alarm_rise, err_sticky});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < EVT_MAX + 2; c++) begin
      for (int k = 0; k < SET_COUNT + CLR_COUNT; k++) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive(1'b0, 3'($urandom()));
        drive(1'b1, (k < SET_COUNT) ? F_GT : (($urandom_range(0, 1) == 1) ? F_LT : F_EQ));
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
          n_err++; $display("FAIL sat[%0d.%0d]: got %b expected %b", c, k, obs_vec(), exp_vec());
        end
      end
    end
    n_vec++;
    if (event_cnt !== CNT_W'(EVT_MAX)) begin
      n_err++; $display("FAIL sat_final: got event_cnt=%0d expected %0d", event_cnt, EVT_MAX);
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [2:0] f;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: f = F_GT;
        5, 6:          f = F_LT;
        7, 8:          f = F_EQ;
        default:       f = 3'($urandom());
      endcase
      drive(v, f);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rand[%0d]: got %b expected %b (v=%b f=%b)", i, obs_vec(), exp_vec(), v, f);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 3'b101);
    for (int i = 0; i < SET_COUNT; i++) drive(1'b1, F_GT);
    n_vec++;
    if ({alarm, err_sticky, event_cnt} !== {2'b11, CNT_W'(1)}) begin
      n_err++; $display("FAIL arst_pre: got %b expected %b", {alarm, err_sticky, event_cnt}, {2'b11, CNT_W'(1)});
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL arst_now: got %b expected %b", obs_vec(), exp_vec());
    end
    @(posedge clk); #1;
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL arst_edge: got %b expected %b", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, F_GT);
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL arst_after: got %b expected %b", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_hysteresis();
    test_clear();
    test_flag_err();
    test_saturate();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
